// File: rtl/alu_rf_2432_if.sv
// =============================================================================
// Module : alu_rf_2432_if
// Desc   : Register-file write/read bus and ALU operand/result bus.
// Rev    : 1.0
// =============================================================================
`default_nettype none

interface alu_rf_2432_if;
   // register file
   logic        i_clk_en;
   logic        i_cs_b;
   logic [3:0]  i_wen;
   logic [3:0]  i_waddr;
   logic [31:0] i_din;
   logic [3:0]  i_raddr_0;
   logic [3:0]  i_raddr_1;
   logic [31:0] o_rf_dout_0;
   logic [31:0] o_rf_dout_1;
   // ALU
   logic [31:0] i_alu_a;
   logic [31:0] i_alu_b;
   logic        i_cin;
   logic        i_vin;
   logic [5:0]  i_opcode;
   logic [31:0] o_alu_dout;
   logic        o_cout;
   logic        o_vout;
   logic        o_qnz;
   logic        o_mcp;

   modport master (
      output i_clk_en, i_cs_b, i_wen, i_waddr, i_din, i_raddr_0, i_raddr_1,
      output i_alu_a, i_alu_b, i_cin, i_vin, i_opcode,
      input  o_rf_dout_0, o_rf_dout_1,
      input  o_alu_dout, o_cout, o_vout, o_qnz, o_mcp
   );

   modport slave (
      input  i_clk_en, i_cs_b, i_wen, i_waddr, i_din, i_raddr_0, i_raddr_1,
      input  i_alu_a, i_alu_b, i_cin, i_vin, i_opcode,
      output o_rf_dout_0, o_rf_dout_1,
      output o_alu_dout, o_cout, o_vout, o_qnz, o_mcp
   );
endinterface

`default_nettype wire

// File: rtl/alu_rf_2432.sv
// =============================================================================
// Module : alu_rf_2432
// Desc   : 16x32 register file (2R/1W, byte enables) and combinational ALU.
//          Define MUL_EN to include the 32x32 multiplier on opcode 3E.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module alu_rf_2432 (
   input  wire logic    i_clk,
   input  wire logic    i_rst,
   alu_rf_2432_if.slave bus
);

   localparam logic [5:0] c_OP_MOV   = 6'h20;
   localparam logic [5:0] c_OP_LMOVT = 6'h30;
   localparam logic [5:0] c_OP_ADD   = 6'h22;
   localparam logic [5:0] c_OP_ADC   = 6'h24;
   localparam logic [5:0] c_OP_SUB   = 6'h26;
   localparam logic [5:0] c_OP_SBC   = 6'h28;
   localparam logic [5:0] c_OP_CMP   = 6'h2A;
   localparam logic [5:0] c_OP_AND   = 6'h2C;
   localparam logic [5:0] c_OP_OR    = 6'h2E;
   localparam logic [5:0] c_OP_XOR   = 6'h32;
   localparam logic [5:0] c_OP_BTST  = 6'h34;
   localparam logic [5:0] c_OP_ASR   = 6'h36;
   localparam logic [5:0] c_OP_LSR   = 6'h38;
   localparam logic [5:0] c_OP_ASL   = 6'h3A;
   localparam logic [5:0] c_OP_ROR   = 6'h3C;
   localparam logic [5:0] c_OP_MUL   = 6'h3E;
   localparam logic [5:0] c_OP_DJNZ  = 6'h10;

   // ---------------------------------------------------------------------------
   // Register file
   // ---------------------------------------------------------------------------
   logic [31:0] rf_q [16];
   logic [31:0] rf_d [16];
   logic        w_we;

   assign w_we = bus.i_clk_en & ~bus.i_cs_b & (bus.i_waddr != 4'd0);

   always_comb begin
      for (int r = 0; r < 16; r++) begin
         rf_d[r] = rf_q[r];
      end
      if (w_we) begin
         for (int n = 0; n < 4; n++) begin
            if (bus.i_wen[n]) begin
               rf_d[bus.i_waddr][8*n +: 8] = bus.i_din[8*n +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      for (int r = 0; r < 16; r++) begin
         if (i_rst) begin
            rf_q[r] <= '0;
         end else begin
            rf_q[r] <= rf_d[r];
         end
      end
   end

   // Reads see only the registered contents, so a same-cycle write is not bypassed.
   assign bus.o_rf_dout_0 = (bus.i_raddr_0 == 4'd0) ? 32'd0 : rf_q[bus.i_raddr_0];
   assign bus.o_rf_dout_1 = (bus.i_raddr_1 == 4'd0) ? 32'd0 : rf_q[bus.i_raddr_1];

   // ---------------------------------------------------------------------------
   // ALU
   // ---------------------------------------------------------------------------
   logic [31:0] w_a;
   logic [31:0] w_b;
   logic [5:0]  w_op;
   logic        w_sub;
   logic        w_add_cin;
   logic [31:0] w_b_eff;
   logic [32:0] w_sum;
   logic        w_add_v;
   logic [4:0]  w_sh;
   logic [31:0] w_lsr;
   logic [31:0] w_asr;
   logic [31:0] w_asl;
   logic [63:0] w_rot;
   logic        w_rsh_out;
   logic        w_lsh_out;
   logic [31:0] w_dout;
   logic        w_cout;
   logic        w_vout;
   logic        w_mcp;

   assign w_a  = bus.i_alu_a;
   assign w_b  = bus.i_alu_b;
   assign w_op = bus.i_opcode;
   assign w_sh = w_b[4:0];

   // One shared adder: subtraction is a + ~b + carry-in.
   always_comb begin
      w_sub     = 1'b0;
      w_add_cin = 1'b0;
      case (w_op)
         c_OP_ADC: w_add_cin = bus.i_cin;
         c_OP_SUB,
         c_OP_CMP: begin
            w_sub     = 1'b1;
            w_add_cin = 1'b1;
         end
         c_OP_SBC: begin
            w_sub     = 1'b1;
            w_add_cin = bus.i_cin;
         end
         default: ;
      endcase
   end

   assign w_b_eff = w_sub ? ~w_b : w_b;
   assign w_sum   = {1'b0, w_a} + {1'b0, w_b_eff} + {32'd0, w_add_cin};
   assign w_add_v = (w_a[31] == w_b_eff[31]) & (w_sum[31] ^ w_a[31]);

   assign w_lsr     = w_a >> w_sh;
   assign w_asr     = 32'($signed(w_a) >>> w_sh);
   assign w_asl     = w_a << w_sh;
   assign w_rot     = {w_a, w_a} >> w_sh;
   // Last bit out: a[n-1] for right shifts/rotate, a[32-n] for left shift.
   assign w_rsh_out = w_a[w_sh - 5'd1];
   assign w_lsh_out = w_a[5'd0 - w_sh];

   always_comb begin
      w_dout = w_sum[31:0];
      w_cout = w_sum[32];
      w_vout = w_add_v;
      w_mcp  = 1'b0;
      case (w_op)
         c_OP_MOV: begin
            w_dout = w_b;
            w_cout = bus.i_cin;
            w_vout = bus.i_vin;
         end
         c_OP_LMOVT: begin
            w_dout = {w_b[15:0], 16'h0000};
            w_cout = bus.i_cin;
            w_vout = bus.i_vin;
         end
         c_OP_AND,
         c_OP_BTST: begin
            w_dout = w_a & w_b;
            w_cout = bus.i_cin;
            w_vout = bus.i_vin;
         end
         c_OP_OR: begin
            w_dout = w_a | w_b;
            w_cout = bus.i_cin;
            w_vout = bus.i_vin;
         end
         c_OP_XOR: begin
            w_dout = w_a ^ w_b;
            w_cout = bus.i_cin;
            w_vout = bus.i_vin;
         end
         c_OP_ASR: begin
            w_dout = w_asr;
            w_cout = (w_sh == 5'd0) ? bus.i_cin : w_rsh_out;
            w_vout = bus.i_vin;
         end
         c_OP_LSR: begin
            w_dout = w_lsr;
            w_cout = (w_sh == 5'd0) ? bus.i_cin : w_rsh_out;
            w_vout = bus.i_vin;
         end
         c_OP_ASL: begin
            w_dout = w_asl;
            w_cout = (w_sh == 5'd0) ? bus.i_cin : w_lsh_out;
            w_vout = bus.i_vin;
         end
         c_OP_ROR: begin
            w_dout = w_rot[31:0];
            w_cout = (w_sh == 5'd0) ? bus.i_cin : w_rsh_out;
            w_vout = bus.i_vin;
         end
`ifdef MUL_EN
         c_OP_MUL: begin
            w_dout = w_a * w_b;
            w_cout = bus.i_cin;
            w_vout = bus.i_vin;
            w_mcp  = 1'b1;
         end
`endif
         // ADD, ADC, SUB, SBC, CMP, DJNZ and unassigned opcodes use the adder.
         default: ;
      endcase
   end

   assign bus.o_alu_dout = w_dout;
   assign bus.o_cout     = w_cout;
   assign bus.o_vout     = w_vout;
   assign bus.o_qnz      = (w_op == c_OP_DJNZ) && (w_dout != 32'd0);
   assign bus.o_mcp      = w_mcp;

endmodule

`default_nettype wire

// File: tb/tb_alu_rf_2432.sv
// =============================================================================
// Module : tb_alu_rf_2432
// Desc   : Self-checking bench: register-file model plus arithmetic ALU model.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module tb_alu_rf_2432;

   typedef struct packed {
      logic [31:0] d;
      logic        c;
      logic        v;
      logic        q;
      logic        m;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] m_rf [16];

   always #5 clk = ~clk;

   alu_rf_2432_if bus ();

   alu_rf_2432 u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Reference ALU built from the opcode table with wide integer arithmetic.
   function automatic res_t alu_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic cin, input logic vin,
                                      input logic [5:0] op);
      res_t r;
      longint unsigned ua = {32'd0, a};
      longint unsigned ub = {32'd0, b};
      longint unsigned s;
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ss;
      logic [31:0] x;
      logic        out;
      int          n;
      r.c = cin; r.v = vin; r.m = 1'b0;
      s = ua + ub; ss = sa + sb;
      r.d = s[31:0]; r.c = s[32]; r.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      case (op)
         6'h20: begin r.d = b; r.c = cin; r.v = vin; end
         6'h30: begin r.d = {b[15:0], 16'h0}; r.c = cin; r.v = vin; end
         6'h24: begin
            s = ua + ub + cin; ss = sa + sb + cin;
            r.d = s[31:0]; r.c = s[32];
            r.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         6'h26, 6'h2A: begin
            s = ua - ub; ss = sa - sb;
            r.d = s[31:0]; r.c = (ua >= ub);
            r.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         6'h28: begin
            s = ua - ub - 1 + cin; ss = sa - sb - 1 + cin;
            r.d = s[31:0]; r.c = (ua + cin) > ub;
            r.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         6'h2C, 6'h34: begin r.d = a & b; r.c = cin; r.v = vin; end
         6'h2E: begin r.d = a | b; r.c = cin; r.v = vin; end
         6'h32: begin r.d = a ^ b; r.c = cin; r.v = vin; end
         6'h36, 6'h38, 6'h3A, 6'h3C: begin
            x = a; out = cin; n = int'(b[4:0]);
            for (int i = 0; i < n; i++) begin
               if (op == 6'h3A) begin out = x[31]; x = {x[30:0], 1'b0}; end
               else begin
                  out = x[0];
                  if (op == 6'h36)      x = {x[31], x[31:1]};
                  else if (op == 6'h38) x = {1'b0, x[31:1]};
                  else                  x = {x[0], x[31:1]};
               end
            end
            r.d = x; r.c = out; r.v = vin;
         end
`ifdef MUL_EN
         6'h3E: begin
            s = ua * ub; r.d = s[31:0]; r.c = cin; r.v = vin; r.m = 1'b1;
         end
`endif
         default: ;
      endcase
      r.q = (op == 6'h10) && (r.d != 32'd0);
      return r;
   endfunction

   task automatic rf_write(input logic [3:0] addr, input logic [3:0] wen,
                           input logic [31:0] d, input logic en, input logic csb);
      @(negedge clk);
      bus.i_waddr = addr; bus.i_wen = wen; bus.i_din = d;
      bus.i_clk_en = en; bus.i_cs_b = csb;
      @(posedge clk);
      if (en && !csb && addr != 4'd0 && !rst)
         for (int k = 0; k < 4; k++) if (wen[k]) m_rf[addr][8*k +: 8] = d[8*k +: 8];
      #1;
      bus.i_clk_en = 1'b0; bus.i_cs_b = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int r = 0; r < 16; r++) m_rf[r] = 32'd0;
      @(negedge clk);
      for (int r = 0; r < 16; r++) begin
         bus.i_raddr_0 = 4'(r); bus.i_raddr_1 = 4'(15 - r);
         #1;
         checks += 2;
         if (bus.o_rf_dout_0 !== 32'd0) begin
            errors++; $display("FAIL reset_rd0 r%0d: got %h want 0", r, bus.o_rf_dout_0);
         end
         if (bus.o_rf_dout_1 !== 32'd0) begin
            errors++; $display("FAIL reset_rd1 r%0d: got %h want 0", 15 - r, bus.o_rf_dout_1);
         end
      end
   endtask

   task automatic test_rf_basic();
      rf_write(4'd5, 4'hF, 32'h12345678, 1'b1, 1'b0);
      @(negedge clk); bus.i_raddr_0 = 4'd5; #1;
      checks++;
      if (bus.o_rf_dout_0 !== 32'h12345678) begin
         errors++; $display("FAIL r5_read: got %h want 12345678", bus.o_rf_dout_0);
      end
      rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
      for (int r = 0; r < 16; r++) m_rf[r] = 32'd0;
      @(negedge clk); #1;
      checks++;
      if (bus.o_rf_dout_0 !== 32'd0) begin
         errors++; $display("FAIL r5_after_rst: got %h want 0", bus.o_rf_dout_0);
      end
   endtask

   task automatic test_byte_enables();
      rf_write(4'd3, 4'hF, 32'hAABBCCDD, 1'b1, 1'b0);
      rf_write(4'd3, 4'b1100, 32'h11112222, 1'b1, 1'b0);
      @(negedge clk); bus.i_raddr_1 = 4'd3; #1;
      checks++;
      if (bus.o_rf_dout_1 !== 32'h1111CCDD) begin
         errors++; $display("FAIL wen_1100: got %h want 1111ccdd", bus.o_rf_dout_1);
      end
      rf_write(4'd3, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
      rf_write(4'd3, 4'hF, 32'hDEADBEEF, 1'b1, 1'b1);
      @(negedge clk); #1;
      checks++;
      if (bus.o_rf_dout_1 !== 32'h1111CCDD) begin
         errors++; $display("FAIL gated_write: got %h want 1111ccdd", bus.o_rf_dout_1);
      end
      rf_write(4'd0, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b0);
      @(negedge clk); bus.i_raddr_0 = 4'd0; #1;
      checks++;
      if (bus.o_rf_dout_0 !== 32'd0) begin
         errors++; $display("FAIL r0_write: got %h want 0", bus.o_rf_dout_0);
      end
   endtask

   task automatic test_rf_random();
      logic [3:0]  wa;
      logic [3:0]  we;
      logic [31:0] wd;
      logic        en;
      logic        csb;
      for (int i = 0; i < 200; i++) begin
         wa = 4'($urandom); we = 4'($urandom); wd = $urandom;
         en = ($urandom_range(0, 3) != 0); csb = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         bus.i_waddr = wa; bus.i_wen = we; bus.i_din = wd;
         bus.i_clk_en = en; bus.i_cs_b = csb;
         bus.i_raddr_0 = wa; bus.i_raddr_1 = 4'($urandom);
         #1;
         checks += 2;
         if (bus.o_rf_dout_0 !== m_rf[wa]) begin
            errors++; $display("FAIL rdw_port0 r%0d: got %h want %h", wa, bus.o_rf_dout_0, m_rf[wa]);
         end
         if (bus.o_rf_dout_1 !== m_rf[bus.i_raddr_1]) begin
            errors++; $display("FAIL rd_port1 r%0d: got %h want %h", bus.i_raddr_1,
                               bus.o_rf_dout_1, m_rf[bus.i_raddr_1]);
         end
         @(posedge clk);
         if (en && !csb && wa != 4'd0)
            for (int k = 0; k < 4; k++) if (we[k]) m_rf[wa][8*k +: 8] = wd[8*k +: 8];
      end
      @(negedge clk); bus.i_clk_en = 1'b0; bus.i_cs_b = 1'b1;
   endtask

   task automatic test_reset_override();
      rf_write(4'd9, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      bus.i_waddr = 4'd9; bus.i_wen = 4'hF; bus.i_din = 32'h55555555;
      bus.i_clk_en = 1'b1; bus.i_cs_b = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; bus.i_clk_en = 1'b0; bus.i_cs_b = 1'b1;
      for (int r = 0; r < 16; r++) m_rf[r] = 32'd0;
      @(negedge clk); bus.i_raddr_0 = 4'd9; #1;
      checks++;
      if (bus.o_rf_dout_0 !== 32'd0) begin
         errors++; $display("FAIL rst_over_write: got %h want 0", bus.o_rf_dout_0);
      end
   endtask

   task automatic test_alu_directed();
      // op, a, b, cin, expected {dout, cout, vout, qnz}
      logic [5:0]  ops [11] = '{6'h22, 6'h26, 6'h2A, 6'h10, 6'h10, 6'h38,
                                6'h3C, 6'h3A, 6'h36, 6'h38, 6'h30};
      logic [31:0] as  [11] = '{32'h7FFFFFFF, 32'h0, 32'h5, 32'h1, 32'h2, 32'h3,
                                32'h1, 32'h80000001, 32'h80000000, 32'h1234, 32'h0};
      logic [31:0] bs  [11] = '{32'h1, 32'h1, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,
                                32'h1, 32'h1, 32'h4, 32'h20, 32'h0000ABCD};
      logic        cs  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [34:0] ex  [11] = '{{32'h80000000, 3'b010}, {32'hFFFFFFFF, 3'b000},
                                {32'h0, 3'b100}, {32'h0, 3'b100}, {32'h1, 3'b101},
                                {32'h1, 3'b100}, {32'h80000000, 3'b100},
                                {32'h2, 3'b100}, {32'hF8000000, 3'b000},
                                {32'h1234, 3'b100}, {32'hABCD0000, 3'b100}};
      logic [34:0] got;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         bus.i_opcode = ops[i]; bus.i_alu_a = as[i]; bus.i_alu_b = bs[i];
         bus.i_cin = cs[i]; bus.i_vin = 1'b0;
         #1;
         got = {bus.o_alu_dout, bus.o_cout, bus.o_vout, bus.o_qnz};
         checks++;
         if (got !== ex[i]) begin
            errors++; $display("FAIL alu_vec%0d op=%h: got {d,c,v,q}=%h want %h", i, ops[i], got, ex[i]);
         end
      end
      @(negedge clk);
      bus.i_opcode = 6'h3E; bus.i_alu_a = 32'h00010000; bus.i_alu_b = 32'h00010001;
      bus.i_cin = 1'b0; bus.i_vin = 1'b0;
      #1;
      checks++;
`ifdef MUL_EN
      if ({bus.o_alu_dout, bus.o_mcp} !== {32'h00010000, 1'b1}) begin
         errors++; $display("FAIL mul: got d=%h mcp=%b want 00010000 1", bus.o_alu_dout, bus.o_mcp);
      end
`else
      if ({bus.o_alu_dout, bus.o_mcp} !== {32'h00020001, 1'b0}) begin
         errors++; $display("FAIL op3e_add: got d=%h mcp=%b want 00020001 0", bus.o_alu_dout, bus.o_mcp);
      end
`endif
   endtask

   task automatic test_alu_random();
      logic [5:0]  oplist [17] = '{6'h20, 6'h30, 6'h22, 6'h24, 6'h26, 6'h28, 6'h2A, 6'h2C,
                                   6'h2E, 6'h32, 6'h34, 6'h36, 6'h38, 6'h3A, 6'h3C, 6'h3E, 6'h10};
      logic [31:0] edges [4] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      res_t        exp_r;
      res_t        got;
      for (int i = 0; i < 400; i++) begin
         op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : oplist[$urandom_range(0, 16)];
         a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
         @(negedge clk);
         bus.i_opcode = op; bus.i_alu_a = a; bus.i_alu_b = b;
         bus.i_cin = 1'($urandom); bus.i_vin = 1'($urandom);
         #1;
         exp_r = alu_model(a, b, bus.i_cin, bus.i_vin, op);
         got   = {bus.o_alu_dout, bus.o_cout, bus.o_vout, bus.o_qnz, bus.o_mcp};
         checks++;
         if (got !== exp_r) begin
            errors++;
            $display("FAIL alu_rand op=%h a=%h b=%h: got {d,c,v,q,m}=%h want %h", op, a, b, got, exp_r);
         end
      end
   endtask

   initial begin
      bus.i_clk_en = 1'b0; bus.i_cs_b = 1'b1; bus.i_wen = 4'h0; bus.i_waddr = 4'd0;
      bus.i_din = 32'd0; bus.i_raddr_0 = 4'd0; bus.i_raddr_1 = 4'd0;
      bus.i_alu_a = 32'd0; bus.i_alu_b = 32'd0; bus.i_cin = 1'b0; bus.i_vin = 1'b0;
      bus.i_opcode = 6'h20;
      test_reset();
      test_rf_basic();
      test_byte_enables();
      test_rf_random();
      test_reset_override();
      test_alu_directed();
      test_alu_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_rf_2432.md
ALU_RF_2432 -- requirements
Module: alu_rf_2432

Interface
REQ-001 SHALL have port i_clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port i_clk_en, input, 1: register-file write qualifier.
REQ-004 SHALL have port i_cs_b, input, 1: register-file chip select, active low.
REQ-005 SHALL have port i_wen, input, 4: byte write enables; bit n covers din[8n+7:8n].
REQ-006 SHALL have port i_waddr, input, 4: write register index.
REQ-007 SHALL have port i_din, input, 32: write data.
REQ-008 SHALL have ports i_raddr_0 and i_raddr_1, input, 4 each: read indices.
REQ-009 SHALL have ports o_rf_dout_0 and o_rf_dout_1, output, 32 each: read data.
REQ-010 SHALL have ports i_alu_a and i_alu_b, input, 32 each: ALU operands.
REQ-011 SHALL have ports i_cin and i_vin, input, 1 each: current carry and overflow flags.
REQ-012 SHALL have port i_opcode, input, 6: ALU operation.
REQ-013 SHALL have port o_alu_dout, output, 32: ALU result.
REQ-014 SHALL have ports o_cout and o_vout, output, 1 each: carry and overflow out.
REQ-015 SHALL have port o_qnz, output, 1: high when o_alu_dout != 0 and opcode is DJNZ, else 0.
REQ-016 SHALL have port o_mcp, output, 1: multicycle request.

Function
REQ-017 Register file: 16 x 32 bits; one write port, two independent read ports.
REQ-018 Reads SHALL be combinational; R0 SHALL always read 0.
REQ-019 Write SHALL occur at the clock edge when i_clk_en=1 and i_cs_b=0 and i_waddr!=0.
- Only bytes with i_wen bit set are updated.
- i_wen=4'b1100 writes the upper halfword only (LMOVT usage).
REQ-020 Read-during-write to the same register SHALL return the old value; no bypass.
REQ-021 ALU SHALL be purely combinational.
REQ-022 Opcodes (hex), result dout:
- 20 MOV = b
- 30 LMOVT = {b[15:0],16'h0}
- 22 ADD = a+b
- 24 ADC = a+b+cin
- 26 SUB = a-b
- 28 SBC = a+~b+cin
- 2A CMP = a-b
- 2C AND = a&b
- 2E OR = a|b
- 32 XOR = a^b
- 34 BTST = a&b
- 36 ASR, 38 LSR, 3A ASL, 3C ROR: a shifted by b[4:0]
- 3E MUL = low 32 bits of a*b
- 10 DJNZ = a+b
- any other opcode = a+b (address add)
REQ-023 Add-type ops (ADD, ADC, DJNZ, default): cout = bit 32 of the sum; vout = signed overflow.
REQ-024 Subtract-type ops (SUB, SBC, CMP): computed as a+~b+1 (SBC: +cin); cout = 1 means no borrow; vout = signed overflow.
REQ-025 Logic ops, MOV, LMOVT, MUL: cout=i_cin, vout=i_vin.
REQ-026 Shifts: cout = last bit shifted out, vout=i_vin; shift amount 0 gives dout=a and cout=i_cin.
REQ-027 All arithmetic SHALL be modulo 2^32; wrap-around SHALL be reflected only in cout/vout.

Reset
REQ-028 While i_rst=1 at a clock edge, all 16 registers SHALL clear to 0, regardless of i_clk_en and i_cs_b; reset overrides a simultaneous write.
REQ-029 ALU outputs SHALL depend only on inputs; they have no reset state.

Configuration
REQ-030 Macro MUL_EN defined: opcode 3E SHALL produce the product; o_mcp SHALL be 1 combinationally while i_opcode=3E, so the caller holds operands for 2 cycles.
REQ-031 MUL_EN undefined: opcode 3E SHALL behave as the default (a+b), o_mcp SHALL be constant 0, and no multiplier SHALL be synthesized.

Verification
REQ-032 Register-file reset and read:
- Write R5=0x12345678 with wen=F, cs_b=0, clk_en=1.
- Next cycle read R5 -> 0x12345678.
- Assert i_rst, then read R5 -> 0.
REQ-033 Byte enables and gating:
- R3=0xAABBCCDD, then write 0x11112222 with wen=1100 -> R3 reads 0x1111CCDD.
- Write with clk_en=0 or cs_b=1 -> no change.
- Write to R0 -> R0 reads 0.
REQ-034 Add: ADD a=0x7FFFFFFF, b=1 -> dout=0x80000000, cout=0, vout=1.
REQ-035 Subtract:
- SUB a=0, b=1 -> dout=0xFFFFFFFF, cout=0, vout=0.
- CMP a=5, b=5 -> dout=0, cout=1.
REQ-036 DJNZ:
- a=1, b=0xFFFFFFFF -> dout=0, qnz=0.
- a=2 -> dout=1, qnz=1.
REQ-037 Shifts and multiply:
- LSR a=0x3, b=1 -> dout=1, cout=1.
- MUL (MUL_EN) 0x10000 x 0x10001 -> dout=0x00010000, mcp=1.
